// File: rtl/arm_pkg.sv
// ============================================================================
// Module      : arm_pkg
// Description : Shared definitions for the ARM pipeline MEM-stage blocks:
//               SRAM controller state encoding, data memory base address and
//               the EXE_CMD encodings issued by the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_pkg;

  // Byte address the data memory window starts at; SRAM word 0 lives here.
  localparam int unsigned DATA_MEM_BASE = 32'd1024;

  // EXE_CMD encodings for the memory instructions.
  localparam logic [3:0] EXE_CMD_LDR = 4'b1010;
  localparam logic [3:0] EXE_CMD_STR = 4'b1011;

  // SRAM controller FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_LO = 3'd1,
    ACC_HI = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } sram_state_t;

endpackage : arm_pkg

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module      : sram_controller
// Description : MEM-stage responder that serves each 32-bit LDR/STR word as
//               two 16-bit accesses to an external asynchronous SRAM and
//               stalls the pipeline (ready low) until the access completes.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               rd_en, wr_en         - mem_read / mem_write strobes
//               address, write_data  - byte address, store data
//               read_data            - registered load result
//               ready                - high: MEM stage may advance
//               SRAM_DQ/ADDR/WE_N    - SRAM data bus, halfword address, WE
//               SRAM_UB/LB/CE/OE_N   - tied active (0)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_controller
  import arm_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DATA_MEM_BASE,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N
);

  localparam int unsigned WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  // With WAIT_CYCLES = 0 the WAIT state is never entered, so the wrapped
  // value of this constant is irrelevant.
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES - 1);

  sram_state_t         state_q, state_d;
  logic [ADDR_W-2:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                op_q, op_d;          // 1 = read
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [31:0]         read_data_q, read_data_d;

  logic [ADDR_W-2:0]   req_idx;
  logic                drive_bus;
  logic [15:0]         dq_out;

  // Word index of the incoming request: (address - BASE_ADDR)[ADDR_W:2].
  // The subtraction wraps modulo 2^32 and there is no range check.
  assign req_idx = (ADDR_W-1)'((address - BASE_ADDR) >> 2);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    wcnt_d      = wcnt_q;
    read_data_d = read_data_q;

    case (state_q)
      IDLE: begin
        if (rd_en | wr_en) begin
          state_d = ACC_LO;
          idx_d   = req_idx;
          wdata_d = write_data;
          op_d    = rd_en;       // read wins when both strobes are high
        end
      end
      ACC_LO: begin
        if (op_q) begin
          read_data_d[15:0] = SRAM_DQ;
        end
        state_d = ACC_HI;
      end
      ACC_HI: begin
        if (op_q) begin
          read_data_d[31:16] = SRAM_DQ;
        end
        wcnt_d  = '0;
        state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        if (wcnt_q == WCNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wdata_q     <= '0;
      op_q        <= 1'b0;
      wcnt_q      <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      wcnt_q      <= wcnt_d;
      read_data_q <= read_data_d;
    end
  end

  // Bus drive and WE_N come only from registered state, so the write strobe
  // cannot glitch on the rd_en/wr_en inputs.
  assign drive_bus = ((state_q == ACC_LO) || (state_q == ACC_HI)) && !op_q;
  assign dq_out    = (state_q == ACC_HI) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = drive_bus ? dq_out : 16'bz;
  assign SRAM_WE_N = ~drive_bus;
  assign SRAM_ADDR = {idx_q, (state_q == ACC_HI)};

  assign read_data = read_data_q;
  // Combinational so the stall shows up in the same cycle as the request.
  assign ready = ((state_q == IDLE) && !rd_en && !wr_en) || (state_q == DONE);

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule : sram_controller

`default_nettype wire
